// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maze_pkg
//  Description : Shared maze geometry, cell indexing and encodings used by the
//                player controller, renderer and map generator.
//  Revision    : 1.0  initial release
// ============================================================================
package maze_pkg;

    localparam int X_DIM    = 5;
    localparam int Y_DIM    = 5;
    localparam int B_LENGTH = 94;
    localparam int B_WIDTH  = 95;
    localparam int X_OFFSET = 81;

    localparam logic [2:0] START_COL = 3'd0;
    localparam logic [2:0] START_ROW = 3'd4;
    localparam logic [2:0] GOAL_COL  = 3'd4;
    localparam logic [2:0] GOAL_ROW  = 3'd0;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_COOL  = 2'd2,
        ST_WIN   = 2'd3
    } state_t;

    // Wall-map bit index for a cell; columns are stored as contiguous runs of rows.
    function automatic logic [4:0] cell_idx(input logic [2:0] col, input logic [2:0] row);
        logic [5:0] w_sum;
        w_sum = 6'(col) * 6'(Y_DIM) + 6'(row);
        return w_sum[4:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_sync_edge
//  Description : Two-flop synchronizer for a raw push-button followed by a
//                rising-edge detector on the synchronized level.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_sync_edge (
    input  logic in_clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge in_clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= btn_raw;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Pulse is formed from registered levels so the FSM sees it the cycle the
    // synchronized level first rises.
    assign btn_edge = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/maze_player_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : maze_player_ctrl
//  Description : Moves a player token across the maze grid from push-buttons,
//                blocking walls and grid edges; reports cell, pixel box, move
//                count, win flag and bump pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int X_DIM    = maze_pkg::X_DIM,
    parameter int Y_DIM    = maze_pkg::Y_DIM,
    parameter int B_LENGTH = maze_pkg::B_LENGTH,
    parameter int B_WIDTH  = maze_pkg::B_WIDTH,
    parameter int X_OFFSET = maze_pkg::X_OFFSET,
    parameter int COOLDOWN = 5000000
) (
    input  logic                     in_clk,
    input  logic                     reset,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic [X_DIM*Y_DIM-1:0]   wall_map,
    input  logic                     map_load,
    output logic [2:0]               player_col,
    output logic [2:0]               player_row,
    output logic [10:0]              player_x1,
    output logic [10:0]              player_x2,
    output logic [10:0]              player_y1,
    output logic [10:0]              player_y2,
    output logic [15:0]              move_count,
    output logic                     won,
    output logic                     bump
);

    localparam int                c_CD_W    = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
    localparam logic [c_CD_W-1:0] c_CD_LOAD = c_CD_W'(COOLDOWN - 1);

    logic [3:0] w_raw;
    logic [3:0] w_edge;

    assign w_raw = {btn_up, btn_down, btn_left, btn_right};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_sync_edge u_sync (
            .in_clk   (in_clk),
            .reset    (reset),
            .btn_raw  (w_raw[gi]),
            .btn_edge (w_edge[gi])
        );
    end

    state_t              r_state;
    dir_t                r_dir;
    logic [2:0]          r_col;
    logic [2:0]          r_row;
    logic [15:0]         r_move_count;
    logic                r_won;
    logic                r_bump;
    logic [c_CD_W-1:0]   r_cd;

    logic        w_edge_valid;
    dir_t        w_edge_dir;
    logic [3:0]  w_tgt_col;
    logic [3:0]  w_tgt_row;
    logic        w_in_grid;
    logic [4:0]  w_tgt_idx;
    logic        w_always_open;
    logic        w_blocked;
    logic        w_tgt_goal;

    // Fixed priority up > down > left > right; losing edges are simply dropped.
    always_comb begin
        w_edge_valid = |w_edge;
        w_edge_dir   = DIR_RIGHT;
        if (w_edge[3]) begin
            w_edge_dir = DIR_UP;
        end else if (w_edge[2]) begin
            w_edge_dir = DIR_DOWN;
        end else if (w_edge[1]) begin
            w_edge_dir = DIR_LEFT;
        end
    end

    // Target computed one bit wider so stepping below 0 wraps to a large,
    // out-of-grid value instead of aliasing onto a real cell.
    always_comb begin
        w_tgt_col = {1'b0, r_col};
        w_tgt_row = {1'b0, r_row};
        case (r_dir)
            DIR_UP:    w_tgt_row = {1'b0, r_row} - 4'd1;
            DIR_DOWN:  w_tgt_row = {1'b0, r_row} + 4'd1;
            DIR_LEFT:  w_tgt_col = {1'b0, r_col} - 4'd1;
            DIR_RIGHT: w_tgt_col = {1'b0, r_col} + 4'd1;
            default:   w_tgt_col = {1'b0, r_col};
        endcase
    end

    assign w_in_grid     = (w_tgt_col < 4'(X_DIM)) && (w_tgt_row < 4'(Y_DIM));
    assign w_tgt_idx     = cell_idx(w_tgt_col[2:0], w_tgt_row[2:0]);
    assign w_tgt_goal    = (w_tgt_col == {1'b0, GOAL_COL}) && (w_tgt_row == {1'b0, GOAL_ROW});
    assign w_always_open = w_tgt_goal ||
                           ((w_tgt_col == {1'b0, START_COL}) && (w_tgt_row == {1'b0, START_ROW}));
    assign w_blocked     = !w_in_grid || (!w_always_open && wall_map[w_tgt_idx]);

    always_ff @(posedge in_clk) begin
        if (reset || map_load) begin
            r_state      <= ST_IDLE;
            r_dir        <= DIR_UP;
            r_col        <= START_COL;
            r_row        <= START_ROW;
            r_move_count <= 16'd0;
            r_won        <= 1'b0;
            r_bump       <= 1'b0;
            r_cd         <= '0;
        end else begin
            r_bump <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_edge_valid) begin
                        r_dir   <= w_edge_dir;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_blocked) begin
                        r_bump  <= 1'b1;
                        r_cd    <= c_CD_LOAD;
                        r_state <= ST_COOL;
                    end else begin
                        r_col <= w_tgt_col[2:0];
                        r_row <= w_tgt_row[2:0];
                        if (r_move_count != 16'hFFFF) begin
                            r_move_count <= r_move_count + 16'd1;
                        end
                        if (w_tgt_goal) begin
                            r_won   <= 1'b1;
                            r_state <= ST_WIN;
                        end else begin
                            r_cd    <= c_CD_LOAD;
                            r_state <= ST_COOL;
                        end
                    end
                end
                ST_COOL: begin
                    if (r_cd == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cd <= r_cd - 1'b1;
                    end
                end
                ST_WIN: begin
                    r_state <= ST_WIN;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign player_col = r_col;
    assign player_row = r_row;
    assign move_count = r_move_count;
    assign won        = r_won;
    assign bump       = r_bump;

    assign player_x1 = 11'(X_OFFSET) + 11'(r_col) * 11'(B_LENGTH);
    assign player_x2 = player_x1 + 11'(B_LENGTH - 1);
    assign player_y1 = 11'(r_row) * 11'(B_WIDTH);
    assign player_y2 = player_y1 + 11'(B_WIDTH - 1);

endmodule
`default_nettype wire

// File: tb/tb_maze_player_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maze_player_ctrl
//  Description : Self-checking bench for maze_player_ctrl: table of button
//                presses with expected results plus multi-cycle sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_maze_player_ctrl;

    localparam int CD = 4;

    logic        in_clk = 1'b0;
    logic        reset;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic [24:0] wall_map;
    logic        map_load;
    logic [2:0]  player_col, player_row;
    logic [10:0] player_x1, player_x2, player_y1, player_y2;
    logic [15:0] move_count;
    logic        won, bump;

    maze_player_ctrl #(.COOLDOWN(CD)) dut (
        .in_clk     (in_clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .wall_map   (wall_map),
        .map_load   (map_load),
        .player_col (player_col),
        .player_row (player_row),
        .player_x1  (player_x1),
        .player_x2  (player_x2),
        .player_y1  (player_y1),
        .player_y2  (player_y2),
        .move_count (move_count),
        .won        (won),
        .bump       (bump)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [2:0]  col;
        logic [2:0]  row;
        logic [15:0] cnt;
        logic        won;
        logic        bump;
    } exp_t;

    typedef struct {
        logic [3:0]  btns;
        logic [24:0] wall;
        logic        load;
        int          hold;
        logic [2:0]  col;
        logic [2:0]  row;
        logic [15:0] cnt;
        logic        won;
        logic        bump;
    } vec_t;

    localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LT = 4'b0010, RT = 4'b0001;

    exp_t sb[$];
    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_state(input logic [2:0] col, input logic [2:0] row,
                                input logic [15:0] cnt, input logic w, input logic b);
        exp_t e;
        e.col = col; e.row = row; e.cnt = cnt; e.won = w; e.bump = b;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got col %0d row %0d", tag, player_col, player_row);
        end else begin
            e = sb.pop_front();
            chk({tag, ".col"},  int'(player_col), int'(e.col));
            chk({tag, ".row"},  int'(player_row), int'(e.row));
            chk({tag, ".cnt"},  int'(move_count), int'(e.cnt));
            chk({tag, ".won"},  int'(won),        int'(e.won));
            chk({tag, ".bump"}, int'(bump),       int'(e.bump));
            chk({tag, ".x1"},   int'(player_x1),  81 + 94 * int'(e.col));
            chk({tag, ".x2"},   int'(player_x2),  81 + 94 * int'(e.col) + 93);
            chk({tag, ".y1"},   int'(player_y1),  95 * int'(e.row));
            chk({tag, ".y2"},   int'(player_y2),  95 * int'(e.row) + 94);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    task automatic drive(input logic [3:0] btns);
        {btn_up, btn_down, btn_left, btn_right} = btns;
    endtask

    task automatic do_load(input logic [24:0] wall);
        wall_map = wall;
        map_load = 1'b1;
        cycles(1);
        map_load = 1'b0;
        cycles(1);
    endtask

    // Result is due on the 4th falling edge after driving (3 rising edges after first sample).
    task automatic press(input logic [3:0] btns, input int hold,
                         input logic [2:0] col, input logic [2:0] row,
                         input logic [15:0] cnt, input logic w, input logic b,
                         input string tag);
        expect_state(col, row, cnt, w, b);
        drive(btns);
        cycles(4);
        check_out(tag);
        cycles(1);
        chk({tag, ".bump_gone"}, int'(bump), 0);
        if (hold > 5) cycles(hold - 5);
        drive(4'b0000);
        cycles(CD + 6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{UP,      25'h0000008, 1'b1, 6, 3'd0, 3'd4, 16'd0, 1'b0, 1'b1};
        vecs[1]  = '{LT,      25'h0000008, 1'b0, 6, 3'd0, 3'd4, 16'd0, 1'b0, 1'b1};
        vecs[2]  = '{DN,      25'h0000008, 1'b0, 6, 3'd0, 3'd4, 16'd0, 1'b0, 1'b1};
        vecs[3]  = '{UP,      25'h0100050, 1'b1, 6, 3'd0, 3'd3, 16'd1, 1'b0, 1'b0};
        vecs[4]  = '{UP,      25'h0100050, 1'b0, 6, 3'd0, 3'd2, 16'd2, 1'b0, 1'b0};
        vecs[5]  = '{UP,      25'h0100050, 1'b0, 6, 3'd0, 3'd1, 16'd3, 1'b0, 1'b0};
        vecs[6]  = '{UP,      25'h0100050, 1'b0, 6, 3'd0, 3'd0, 16'd4, 1'b0, 1'b0};
        vecs[7]  = '{RT,      25'h0100050, 1'b0, 6, 3'd1, 3'd0, 16'd5, 1'b0, 1'b0};
        vecs[8]  = '{RT,      25'h0100050, 1'b0, 6, 3'd2, 3'd0, 16'd6, 1'b0, 1'b0};
        vecs[9]  = '{RT,      25'h0100050, 1'b0, 6, 3'd3, 3'd0, 16'd7, 1'b0, 1'b0};
        vecs[10] = '{RT,      25'h0100050, 1'b0, 6, 3'd4, 3'd0, 16'd8, 1'b1, 1'b0};
        vecs[11] = '{LT,      25'h0100050, 1'b0, 6, 3'd4, 3'd0, 16'd8, 1'b1, 1'b0};
        vecs[12] = '{DN,      25'h0100050, 1'b0, 6, 3'd4, 3'd0, 16'd8, 1'b1, 1'b0};
        vecs[13] = '{UP | RT, 25'h0000000, 1'b1, 6, 3'd0, 3'd3, 16'd1, 1'b0, 1'b0};
        vecs[14] = '{UP,      25'h0000004, 1'b0, 6, 3'd0, 3'd3, 16'd1, 1'b0, 1'b1};
        vecs[15] = '{RT,      25'h000000C, 1'b0, 6, 3'd1, 3'd3, 16'd2, 1'b0, 1'b0};

        reset    = 1'b1;
        map_load = 1'b0;
        wall_map = 25'h0;
        drive(4'b0000);
        cycles(3);
        expect_state(3'd0, 3'd4, 16'd0, 1'b0, 1'b0);
        check_out("reset");
        reset = 1'b0;
        cycles(1);

        // Exact latency and single move from a long hold.
        expect_state(3'd0, 3'd4, 16'd0, 1'b0, 1'b0);
        drive(UP);
        cycles(3);
        check_out("lat_before");
        expect_state(3'd0, 3'd3, 16'd1, 1'b0, 1'b0);
        cycles(1);
        check_out("lat_move");
        cycles(96);
        expect_state(3'd0, 3'd3, 16'd1, 1'b0, 1'b0);
        check_out("hold100");
        drive(4'b0000);
        cycles(CD + 6);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].load) do_load(vecs[i].wall);
            else wall_map = vecs[i].wall;
            press(vecs[i].btns, vecs[i].hold, vecs[i].col, vecs[i].row, vecs[i].cnt,
                  vecs[i].won, vecs[i].bump, $sformatf("vec%0d", i));
        end

        // Press arriving during cooldown is discarded.
        do_load(25'h0);
        drive(UP);
        cycles(4);
        expect_state(3'd0, 3'd3, 16'd1, 1'b0, 1'b0);
        check_out("cool_first");
        drive(UP | RT);
        cycles(3);
        drive(4'b0000);
        cycles(CD + 6);
        expect_state(3'd0, 3'd3, 16'd1, 1'b0, 1'b0);
        check_out("cool_ignored");

        // map_load landing on the CHECK cycle aborts the move.
        drive(UP);
        cycles(3);
        map_load = 1'b1;
        cycles(1);
        map_load = 1'b0;
        expect_state(3'd0, 3'd4, 16'd0, 1'b0, 1'b0);
        check_out("load_in_check");
        cycles(1);
        chk("load_in_check.no_bump", int'(bump), 0);
        drive(4'b0000);
        cycles(CD + 6);
        expect_state(3'd0, 3'd4, 16'd0, 1'b0, 1'b0);
        check_out("load_in_check.settled");

        // Reset in the middle of cooldown.
        drive(UP);
        cycles(5);
        expect_state(3'd0, 3'd3, 16'd1, 1'b0, 1'b0);
        check_out("pre_reset_cool");
        reset = 1'b1;
        drive(4'b0000);
        cycles(1);
        reset = 1'b0;
        expect_state(3'd0, 3'd4, 16'd0, 1'b0, 1'b0);
        check_out("reset_in_cool");
        cycles(CD + 6);
        expect_state(3'd0, 3'd4, 16'd0, 1'b0, 1'b0);
        check_out("reset_in_cool.settled");

        // Saturation of the move counter.
        force dut.r_move_count = 16'hFFFE;
        cycles(1);
        release dut.r_move_count;
        cycles(1);
        press(UP, 6, 3'd0, 3'd3, 16'hFFFF, 1'b0, 1'b0, "sat_first");
        press(DN, 6, 3'd0, 3'd4, 16'hFFFF, 1'b0, 1'b0, "sat_hold");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
